// File: rtl/log2_share_ctrl.sv
// ---------------------------------------------------------------------------
// log2_share_ctrl
//
// Round-robin scheduler that shares one floor(log2) engine among NREQ
// requesters. A requester raises its req bit with an operand on its slot of
// req_n_i; the controller grants one requester at a time, launches the engine
// with a one-cycle start pulse, waits for the engine's done pulse (bounded by
// a watchdog) and returns the 8-bit result to the owner over valid/ready.
//
// Parameters
//   NREQ       number of requesters (2..8)
//   TO_CYCLES  cycles spent waiting for eng_done_i before a timeout (>=16)
//
// Ports
//   clk          in   clock, rising edge
//   resetb       in   asynchronous, active-low reset
//   req_i        in   [NREQ]   level request per requester
//   req_n_i      in   [NREQ*8] operands, slot i = req_n_i[8*i+7:8*i]
//   gnt_o        out  [NREQ]   one-hot 1-cycle pulse: operand captured
//   rsp_valid_o  out  [NREQ]   one-hot: response belongs to this requester
//   rsp_ready_i  in   [NREQ]   per-requester response accept
//   rsp_r_o      out  [8]      floor(log2 N), 0 for N=0/1, 0 on timeout
//   rsp_err_o    out  1        engine timed out
//   eng_start_o  out  1        1-cycle start pulse to the engine
//   eng_n_o      out  [8]      operand to the engine, held until next grant
//   eng_done_i   in   1        engine done pulse
//   eng_r_i      in   [8]      engine result, valid with eng_done_i
//   busy_o       out  1        controller not idle
//   state_o      out  [2]      debug view of the FSM state
// ---------------------------------------------------------------------------
module log2_share_ctrl #(
    parameter int NREQ      = 4,
    parameter int TO_CYCLES = 32
) (
    input  logic                clk,
    input  logic                resetb,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*8-1:0]   req_n_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     rsp_valid_o,
    input  logic [NREQ-1:0]     rsp_ready_i,
    output logic [7:0]          rsp_r_o,
    output logic                rsp_err_o,
    output logic                eng_start_o,
    output logic [7:0]          eng_n_o,
    input  logic                eng_done_i,
    input  logic [7:0]          eng_r_i,
    output logic                busy_o,
    output logic [1:0]          state_o
);

    localparam int IW = $clog2(NREQ);
    // Watchdog only has to reach TO_CYCLES-1.
    localparam int WW = $clog2(TO_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e            state_q,     state_d;
    logic [IW-1:0]     owner_q,     owner_d;
    logic [IW-1:0]     last_q,      last_d;
    logic [NREQ-1:0]   gnt_q,       gnt_d;
    logic              eng_start_q, eng_start_d;
    logic [7:0]        eng_n_q,     eng_n_d;
    logic [WW-1:0]     wdog_q,      wdog_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_r_q,     rsp_r_d;
    logic              rsp_err_q,   rsp_err_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     cand;

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Round-robin pick: first set req bit searching upward from last_q+1
    // with wrap. The loop runs from the farthest candidate to the nearest so
    // the nearest one is assigned last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        gnt_d       = '0;          // gnt and eng_start are single-cycle pulses
        eng_start_d = 1'b0;
        eng_n_d     = eng_n_q;
        wdog_d      = wdog_q;
        rsp_valid_d = rsp_valid_q;
        rsp_r_d     = rsp_r_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d     = pick_idx;
                    gnt_d       = onehot(pick_idx);
                    eng_n_d     = req_n_i[{pick_idx, 3'b000} +: 8];
                    eng_start_d = 1'b1;
                    wdog_d      = '0;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // eng_done wins over a timeout landing in the same cycle.
                if (eng_done_i) begin
                    rsp_r_d     = eng_r_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = onehot(owner_q);
                    state_d     = ST_RESP;
                end else if (wdog_q == WW'(TO_CYCLES - 1)) begin
                    rsp_r_d     = 8'h00;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = onehot(owner_q);
                    state_d     = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            ST_RESP: begin
                // Only the owner's ready matters; rsp_r keeps its value.
                if (rsp_ready_i[owner_q]) begin
                    rsp_valid_d = '0;
                    rsp_err_d   = 1'b0;
                    last_d      = owner_q;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding 2'b11: drop any response and go idle.
                rsp_valid_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= IW'(NREQ - 1);   // requester 0 is first in line
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            eng_n_q     <= 8'h00;
            wdog_q      <= '0;
            rsp_valid_q <= '0;
            rsp_r_q     <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            eng_n_q     <= eng_n_d;
            wdog_q      <= wdog_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign eng_start_o = eng_start_q;
    assign eng_n_o     = eng_n_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_r_o     = rsp_r_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign state_o     = state_q;

endmodule
